// File: rtl/oldland_mem_stage_if.sv
// Data-bus bundle between the oldland memory stage (master) and the memory system (slave).
interface oldland_mem_stage_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [3:0]            d_bytesel;
    logic                  d_wr_en;
    logic [31:0]           d_wr_val;
    logic [31:0]           d_data;
    logic                  d_access;
    logic                  d_ack;
    logic                  d_error;

    modport master (
        output d_addr, d_bytesel, d_wr_en, d_wr_val, d_access,
        input  d_data, d_ack, d_error
    );

    modport slave (
        input  d_addr, d_bytesel, d_wr_en, d_wr_val, d_access,
        output d_data, d_ack, d_error
    );
endinterface

// File: rtl/oldland_mem_stage.sv
// Oldland memory stage: multi-cycle load/store unit with lane steering, load extension,
// and misaligned / bus-error / timeout fault reporting; non-memory results bypass in one cycle.
module oldland_mem_stage #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned REG_SEL_WIDTH  = 3,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     store,
    input  logic [ADDR_WIDTH-1:0]    addr,
    input  logic [31:0]              mdr,
    input  logic [1:0]               width,
    input  logic                     signed_ld,
    input  logic [31:0]              wr_val,
    input  logic                     update_rd,
    input  logic [REG_SEL_WIDTH-1:0] rd_sel,
    output logic [31:0]              reg_wr_val,
    output logic                     update_rd_out,
    output logic [REG_SEL_WIDTH-1:0] rd_sel_out,
    output logic                     complete,
    output logic                     stall,
    output logic                     fault,
    output logic [1:0]               fault_cause,
    output logic [ADDR_WIDTH-1:0]    fault_addr,
    oldland_mem_stage_if.master      bus
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [1:0] W_BYTE         = 2'b00;
    localparam logic [1:0] W_HALF         = 2'b01;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_BUS_ERR  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    typedef enum logic {
        IDLE,
        BUS
    } state_t;

    state_t                   state;
    logic [CNT_W-1:0]         tmo_cnt;
    logic [1:0]               lat_width;
    logic                     lat_signed;
    logic [ADDR_WIDTH-1:0]    lat_addr;
    logic [REG_SEL_WIDTH-1:0] lat_rd;

    logic                     misaligned_c;
    logic                     timeout_hit_c;
    logic [3:0]               bytesel_c;
    logic [31:0]              st_data_c;
    logic [31:0]              ld_shifted_c;
    logic [31:0]              ld_val_c;

    // Request decode: alignment and store lane steering from the live address.
    always_comb begin
        misaligned_c = 1'b0;
        bytesel_c    = 4'b1111;
        st_data_c    = mdr;
        case (width)
            W_BYTE: begin
                bytesel_c = 4'b0001 << addr[1:0];
                st_data_c = mdr << {addr[1:0], 3'b000};
            end
            W_HALF: begin
                misaligned_c = addr[0];
                bytesel_c    = 4'b0011 << {addr[1], 1'b0};
                st_data_c    = mdr << {addr[1], 4'b0000};
            end
            default: misaligned_c = (addr[1:0] != 2'b00);
        endcase
    end

    // Load lane extraction; halves are always 2-byte aligned so a byte-granular shift suffices.
    always_comb begin
        ld_shifted_c = bus.d_data >> {lat_addr[1:0], 3'b000};
        case (lat_width)
            W_BYTE:  ld_val_c = {{24{lat_signed & ld_shifted_c[7]}}, ld_shifted_c[7:0]};
            W_HALF:  ld_val_c = {{16{lat_signed & ld_shifted_c[15]}}, ld_shifted_c[15:0]};
            default: ld_val_c = bus.d_data;
        endcase
    end

    always_comb begin
        timeout_hit_c = (TIMEOUT_CYCLES != 0) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
        stall         = 1'b0;
        if (state == IDLE) begin
            stall = load | store;
        end else begin
            stall = !(bus.d_ack | bus.d_error | timeout_hit_c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            tmo_cnt       <= '0;
            lat_width     <= '0;
            lat_signed    <= 1'b0;
            lat_addr      <= '0;
            lat_rd        <= '0;
            reg_wr_val    <= '0;
            update_rd_out <= 1'b0;
            rd_sel_out    <= '0;
            complete      <= 1'b0;
            fault         <= 1'b0;
            fault_cause   <= '0;
            fault_addr    <= '0;
            bus.d_addr    <= '0;
            bus.d_bytesel <= '0;
            bus.d_wr_en   <= 1'b0;
            bus.d_wr_val  <= '0;
            bus.d_access  <= 1'b0;
        end else begin
            complete <= 1'b0;
            fault    <= 1'b0;
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (load | store) begin
                        update_rd_out <= 1'b0;
                        if (misaligned_c) begin
                            fault       <= 1'b1;
                            fault_cause <= CAUSE_MISALIGN;
                            fault_addr  <= addr;
                            complete    <= 1'b1;
                        end else begin
                            bus.d_addr    <= {addr[ADDR_WIDTH-1:2], 2'b00};
                            bus.d_bytesel <= bytesel_c;
                            bus.d_wr_val  <= st_data_c;
                            bus.d_wr_en   <= store;
                            bus.d_access  <= 1'b1;
                            lat_width     <= width;
                            lat_signed    <= signed_ld;
                            lat_addr      <= addr;
                            lat_rd        <= rd_sel;
                            state         <= BUS;
                        end
                    end else begin
                        reg_wr_val    <= wr_val;
                        update_rd_out <= update_rd;
                        rd_sel_out    <= rd_sel;
                    end
                end
                BUS: begin
                    tmo_cnt       <= tmo_cnt + CNT_W'(1);
                    update_rd_out <= 1'b0;
                    // Error takes priority over a simultaneous ack.
                    if (bus.d_error) begin
                        fault        <= 1'b1;
                        fault_cause  <= CAUSE_BUS_ERR;
                        fault_addr   <= lat_addr;
                        complete     <= 1'b1;
                        bus.d_access <= 1'b0;
                        bus.d_wr_en  <= 1'b0;
                        state        <= IDLE;
                    end else if (bus.d_ack) begin
                        complete <= 1'b1;
                        if (!bus.d_wr_en) begin
                            reg_wr_val    <= ld_val_c;
                            update_rd_out <= 1'b1;
                            rd_sel_out    <= lat_rd;
                        end
                        bus.d_access <= 1'b0;
                        bus.d_wr_en  <= 1'b0;
                        state        <= IDLE;
                    end else if (timeout_hit_c) begin
                        fault        <= 1'b1;
                        fault_cause  <= CAUSE_TIMEOUT;
                        fault_addr   <= lat_addr;
                        complete     <= 1'b1;
                        bus.d_access <= 1'b0;
                        bus.d_wr_en  <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oldland_mem_stage.sv
// Self-checking bench for oldland_mem_stage: directed vector table, hand sequences, and
// randomized transactions against a byte-arithmetic reference model.
module tb_oldland_mem_stage;

    localparam int unsigned AW  = 32;
    localparam int unsigned RW  = 3;
    localparam int unsigned TMO = 4;

    localparam int R_ACK  = 0;
    localparam int R_ERR  = 1;
    localparam int R_BOTH = 2;
    localparam int R_NONE = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          load, store, signed_ld, update_rd;
    logic [AW-1:0] addr;
    logic [31:0]   mdr, wr_val;
    logic [1:0]    width;
    logic [RW-1:0] rd_sel;
    logic [31:0]   reg_wr_val;
    logic          update_rd_out, complete, stall, fault;
    logic [RW-1:0] rd_sel_out;
    logic [1:0]    fault_cause;
    logic [AW-1:0] fault_addr;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [31:0]   last_faddr;

    oldland_mem_stage_if #(.ADDR_WIDTH(AW)) bus ();

    oldland_mem_stage #(
        .ADDR_WIDTH    (AW),
        .REG_SEL_WIDTH (RW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .store        (store),
        .addr         (addr),
        .mdr          (mdr),
        .width        (width),
        .signed_ld    (signed_ld),
        .wr_val       (wr_val),
        .update_rd    (update_rd),
        .rd_sel       (rd_sel),
        .reg_wr_val   (reg_wr_val),
        .update_rd_out(update_rd_out),
        .rd_sel_out   (rd_sel_out),
        .complete     (complete),
        .stall        (stall),
        .fault        (fault),
        .fault_cause  (fault_cause),
        .fault_addr   (fault_addr),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ld;
        bit          st;
        logic [31:0] a;
        logic [31:0] md;
        logic [1:0]  w;
        bit          sg;
        logic [2:0]  rd;
        logic [31:0] data;
        int          waits;
        int          resp;
        logic [3:0]  e_bsel;
        logic [31:0] e_wv;
        logic [31:0] e_reg;
        logic [1:0]  e_cause;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: access size in bytes and the byte offset of its lowest lane.
    function automatic int nbytes(input logic [1:0] w);
        return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    endfunction

    function automatic int lane_base(input logic [31:0] a, input logic [1:0] w);
        int n = nbytes(w);
        return (int'(a % 4) / n) * n;
    endfunction

    function automatic logic [3:0] m_bsel(input logic [31:0] a, input logic [1:0] w);
        int v = ((1 << nbytes(w)) - 1) << lane_base(a, w);
        return 4'(v);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] a, input logic [1:0] w,
                                            input logic [31:0] md);
        longint v = longint'(md) << (8 * lane_base(a, w));
        return 32'(v);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] w,
                                           input bit sg, input logic [31:0] data);
        int     n    = nbytes(w);
        longint full = longint'(1) << (8 * n);
        longint v    = (longint'(data) >> (8 * lane_base(a, w))) % full;
        if (sg && n < 4 && v >= full / 2) v = v - full;
        return 32'(v);
    endfunction

    function automatic logic [1:0] m_cause(input logic [31:0] a, input logic [1:0] w,
                                           input int waits, input int resp);
        if ((a % nbytes(w)) != 0) return 2'd1;
        if (resp == R_NONE || waits >= int'(TMO)) return 2'd3;
        if (resp == R_ERR || resp == R_BOTH) return 2'd2;
        return 2'd0;
    endfunction

    // One memory op from issue (cycle N) to result (M+1); returns with inputs idle.
    task automatic do_mem(input vec_t v, input string tag);
        bit done = 0;
        load      = v.ld;
        store     = v.st;
        addr      = v.a;
        mdr       = v.md;
        width     = v.w;
        signed_ld = v.sg;
        rd_sel    = v.rd;
        update_rd = 1'b1;
        wr_val    = 32'hCAFE_0000;
        #1 chk({tag, ".stall_issue"}, 32'(stall), 32'd1);
        tick();
        if (v.e_cause == 2'd1) begin
            chk({tag, ".fault"}, 32'(fault), 32'd1);
            chk({tag, ".cause"}, 32'(fault_cause), 32'd1);
            chk({tag, ".faddr"}, fault_addr, v.a);
            chk({tag, ".complete"}, 32'(complete), 32'd1);
            chk({tag, ".upd"}, 32'(update_rd_out), 32'd0);
            chk({tag, ".no_access"}, 32'(bus.d_access), 32'd0);
            last_faddr = v.a;
        end else begin
            chk({tag, ".d_addr"}, bus.d_addr, v.a & 32'hFFFF_FFFC);
            chk({tag, ".bsel"}, 32'(bus.d_bytesel), 32'(v.e_bsel));
            chk({tag, ".wr_en"}, 32'(bus.d_wr_en), 32'(v.st));
            chk({tag, ".wr_val"}, bus.d_wr_val, v.e_wv);
            for (int k = 0; k < int'(TMO) && !done; k++) begin
                chk({tag, ".access"}, 32'(bus.d_access), 32'd1);
                if (v.resp != R_NONE && k == v.waits) begin
                    bus.d_ack   = (v.resp == R_ACK || v.resp == R_BOTH);
                    bus.d_error = (v.resp == R_ERR || v.resp == R_BOTH);
                    bus.d_data  = v.data;
                    #1 chk({tag, ".stall_resp"}, 32'(stall), 32'd0);
                    done = 1;
                end else if (k == int'(TMO) - 1) begin
                    bus.d_data = $urandom;
                    #1 chk({tag, ".stall_tmo"}, 32'(stall), 32'd0);
                    done = 1;
                end else begin
                    bus.d_data = $urandom;
                    #1 chk({tag, ".stall_wait"}, 32'(stall), 32'd1);
                end
                tick();
                bus.d_ack   = 1'b0;
                bus.d_error = 1'b0;
            end
            chk({tag, ".complete"}, 32'(complete), 32'd1);
            chk({tag, ".fault"}, 32'(fault), 32'(v.e_cause != 2'd0));
            chk({tag, ".access_drop"}, 32'(bus.d_access), 32'd0);
            chk({tag, ".upd"}, 32'(update_rd_out), 32'(v.e_cause == 2'd0 && !v.st));
            if (v.e_cause != 2'd0) begin
                chk({tag, ".cause"}, 32'(fault_cause), 32'(v.e_cause));
                chk({tag, ".faddr"}, fault_addr, v.a);
                last_faddr = v.a;
            end else if (!v.st) begin
                chk({tag, ".ld_val"}, reg_wr_val, v.e_reg);
                chk({tag, ".rd_out"}, 32'(rd_sel_out), 32'(v.rd));
            end
        end
        load      = 1'b0;
        store     = 1'b0;
        update_rd = 1'b0;
    endtask

    // Non-memory op; bus responses in IDLE must be ignored.
    task automatic bypass_op(input logic [31:0] val, input logic [2:0] rd, input bit upd,
                             input string tag);
        load        = 1'b0;
        store       = 1'b0;
        wr_val      = val;
        rd_sel      = rd;
        update_rd   = upd;
        bus.d_ack   = 1'($urandom_range(0, 1));
        bus.d_error = 1'($urandom_range(0, 1));
        #1 chk({tag, ".stall"}, 32'(stall), 32'd0);
        tick();
        bus.d_ack   = 1'b0;
        bus.d_error = 1'b0;
        chk({tag, ".val"}, reg_wr_val, val);
        chk({tag, ".upd"}, 32'(update_rd_out), 32'(upd));
        chk({tag, ".rd"}, 32'(rd_sel_out), 32'(rd));
        chk({tag, ".complete"}, 32'(complete), 32'd0);
        chk({tag, ".fault"}, 32'(fault), 32'd0);
        chk({tag, ".access"}, 32'(bus.d_access), 32'd0);
        chk({tag, ".faddr_hold"}, fault_addr, last_faddr);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".reg_wr_val"}, reg_wr_val, 32'd0);
        chk({tag, ".upd"}, 32'(update_rd_out), 32'd0);
        chk({tag, ".rd"}, 32'(rd_sel_out), 32'd0);
        chk({tag, ".complete"}, 32'(complete), 32'd0);
        chk({tag, ".fault"}, 32'(fault), 32'd0);
        chk({tag, ".cause"}, 32'(fault_cause), 32'd0);
        chk({tag, ".faddr"}, fault_addr, 32'd0);
        chk({tag, ".access"}, 32'(bus.d_access), 32'd0);
        chk({tag, ".d_addr"}, bus.d_addr, 32'd0);
        chk({tag, ".bsel"}, 32'(bus.d_bytesel), 32'd0);
        chk({tag, ".wr_en"}, 32'(bus.d_wr_en), 32'd0);
        chk({tag, ".wr_val"}, bus.d_wr_val, 32'd0);
    endtask

    initial begin
        vec_t v;
        int   r;

        vecs[0]  = '{1, 0, 32'h100,  32'h0,         2'b10, 0, 3'd3, 32'hDEADBEEF, 3, R_ACK,  4'hF, 32'h0,         32'hDEADBEEF, 2'd0};
        vecs[1]  = '{1, 0, 32'h1003, 32'h0,         2'b00, 1, 3'd1, 32'h80123456, 1, R_ACK,  4'h8, 32'h0,         32'hFFFFFF80, 2'd0};
        vecs[2]  = '{1, 0, 32'h1003, 32'h0,         2'b00, 0, 3'd1, 32'h80123456, 1, R_ACK,  4'h8, 32'h0,         32'h00000080, 2'd0};
        vecs[3]  = '{0, 1, 32'h2002, 32'h0000ABCD,  2'b01, 0, 3'd2, 32'h0,        0, R_ACK,  4'hC, 32'hABCD0000,  32'h0,        2'd0};
        vecs[4]  = '{1, 0, 32'h3001, 32'h0,         2'b10, 0, 3'd4, 32'h0,        0, R_ACK,  4'h0, 32'h0,         32'h0,        2'd1};
        vecs[5]  = '{1, 0, 32'h400,  32'h0,         2'b10, 0, 3'd6, 32'h11112222, 1, R_BOTH, 4'hF, 32'h0,         32'h0,        2'd2};
        vecs[6]  = '{1, 0, 32'h500,  32'h0,         2'b10, 0, 3'd7, 32'h0,        0, R_NONE, 4'hF, 32'h0,         32'h0,        2'd3};
        vecs[7]  = '{1, 0, 32'h602,  32'h0,         2'b01, 1, 3'd1, 32'h80011234, 2, R_ACK,  4'hC, 32'h0,         32'hFFFF8001, 2'd0};
        vecs[8]  = '{0, 1, 32'h701,  32'h12345678,  2'b00, 0, 3'd2, 32'h0,        0, R_ACK,  4'h2, 32'h34567800,  32'h0,        2'd0};
        vecs[9]  = '{1, 0, 32'h804,  32'h0,         2'b11, 0, 3'd3, 32'hA5A5A5A5, 0, R_ACK,  4'hF, 32'h0,         32'hA5A5A5A5, 2'd0};
        vecs[10] = '{1, 0, 32'h901,  32'h0,         2'b01, 0, 3'd3, 32'h0,        0, R_ACK,  4'h0, 32'h0,         32'h0,        2'd1};
        vecs[11] = '{0, 1, 32'hA00,  32'hCAFEBABE,  2'b10, 0, 3'd0, 32'h0,        2, R_ERR,  4'hF, 32'hCAFEBABE,  32'h0,        2'd2};

        rst         = 1'b1;
        load        = 1'b0;
        store       = 1'b0;
        addr        = '0;
        mdr         = '0;
        width       = '0;
        signed_ld   = 1'b0;
        wr_val      = '0;
        update_rd   = 1'b0;
        rd_sel      = '0;
        bus.d_data  = '0;
        bus.d_ack   = 1'b0;
        bus.d_error = 1'b0;
        last_faddr  = '0;

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        chk("reset.stall", 32'(stall), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_mem(vecs[i], $sformatf("vec%0d", i));
            bypass_op($urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      $sformatf("vec%0d.after", i));
        end

        // Load immediately followed by a bypass op.
        do_mem(vecs[0], "b2b.load");
        bypass_op(32'h55, 3'd5, 1'b1, "b2b.bypass");

        // Reset asserted while the bus access is outstanding.
        load   = 1'b1;
        addr   = 32'h40;
        width  = 2'b10;
        rd_sel = 3'd2;
        tick();
        chk("midrst.access_before", 32'(bus.d_access), 32'd1);
        rst = 1'b1;
        tick();
        chk_all_zero("midrst");
        rst        = 1'b0;
        load       = 1'b0;
        last_faddr = '0;
        bypass_op(32'h55, 3'd5, 1'b1, "midrst.idle");

        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 2));
            if (r == 0) begin
                bypass_op($urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          $sformatf("rnd%0d.byp", i));
            end else begin
                v.st    = ($urandom_range(0, 1) == 1);
                v.ld    = !v.st;
                v.a     = $urandom;
                if ($urandom_range(0, 2) != 0) v.a[1:0] = 2'b00;
                v.md    = $urandom;
                v.w     = 2'($urandom_range(0, 3));
                v.sg    = 1'($urandom_range(0, 1));
                v.rd    = 3'($urandom_range(0, 7));
                v.data  = $urandom;
                v.waits = int'($urandom_range(0, 5));
                case ($urandom_range(0, 5))
                    3:       v.resp = R_ERR;
                    4:       v.resp = R_BOTH;
                    5:       v.resp = R_NONE;
                    default: v.resp = R_ACK;
                endcase
                v.e_bsel  = m_bsel(v.a, v.w);
                v.e_wv    = m_wdata(v.a, v.w, v.md);
                v.e_reg   = m_load(v.a, v.w, v.sg, v.data);
                v.e_cause = m_cause(v.a, v.w, v.waits, v.resp);
                do_mem(v, $sformatf("rnd%0d", i));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/oldland_mem_stage.md
Name: oldland_mem_stage

Overview:
Parametrised memory stage for the oldland pipeline: a multi-cycle load/store unit between the execute and writeback stages.
- Drives the data bus with byte/half/word lanes.
- Holds the pipeline via stall until the bus acknowledges.
- Sign- or zero-extends load data.
- Detects misaligned accesses, bus errors and bus timeouts, reporting them as a one-cycle fault.
- Non-memory instructions pass through with one-cycle register latency.

Parameters:
ADDR_WIDTH, 32, data-bus address width; addr, d_addr and fault_addr are this wide.
REG_SEL_WIDTH, 3, destination register select width.
TIMEOUT_CYCLES, 255, cycles in BUS without ack/error before abort; 0 disables the timeout.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
load  in  1  memory load request
store  in  1  memory store request
addr  in  ADDR_WIDTH  byte address
mdr  in  32  store data, right-aligned
width  in  2  00 byte, 01 half, 10 word, 11 treated as word
signed_ld  in  1  1 = sign-extend byte/half loads
wr_val  in  32  non-memory result to bypass
update_rd  in  1  non-memory writeback enable
rd_sel  in  REG_SEL_WIDTH  destination register
reg_wr_val  out  32  writeback value (registered)
update_rd_out  out  1  writeback enable (registered)
rd_sel_out  out  REG_SEL_WIDTH  destination register (registered)
complete  out  1  one-cycle pulse: memory op retired (success or fault)
stall  out  1  upstream must hold all inputs stable
fault  out  1  one-cycle fault pulse
fault_cause  out  2  01 misaligned, 10 bus error, 11 timeout
fault_addr  out  ADDR_WIDTH  address of the last faulting access
d_addr  out  ADDR_WIDTH  word-aligned bus address
d_bytesel  out  4  byte lane enables
d_wr_en  out  1  bus write
d_wr_val  out  32  lane-rotated store data
d_data  in  32  bus read data
d_access  out  1  bus request
d_ack  in  1  bus completion
d_error  in  1  bus error completion

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: every output is 0, state = IDLE and the timeout counter is cleared.
- Reset mid-BUS: d_access is 0 on the next cycle; no complete, no fault.
- FSM has two states, IDLE and BUS.
- IDLE with load|store:
  - stall=1 combinationally.
  - Misaligned access (half with addr[0]=1, or word with addr[1:0]!=0): no bus access. Next cycle: fault=1, fault_cause=01, fault_addr=addr, complete=1, update_rd_out=0; FSM stays IDLE.
  - Aligned access: latch d_addr={addr[ADDR_WIDTH-1:2],00}, d_bytesel, d_wr_val, d_wr_en=store, width, signed_ld, addr[1:0] and rd_sel. Go to BUS.
- Lane mapping:
  - Byte: bytesel = 0001<<addr[1:0], data shifted by 8*addr[1:0].
  - Half: bytesel = 0011<<(2*addr[1]), data shifted by 16*addr[1].
  - Word: bytesel = 1111, no shift.
- BUS state:
  - d_access=1 and stall=1; bus outputs stable for the whole state; counter increments each cycle.
  - d_error=1 (wins over a simultaneous d_ack): next cycle fault=1, cause=10, complete=1, update_rd_out=0. Go to IDLE.
  - d_ack=1 and no error: next cycle complete=1. For a load: reg_wr_val = extracted lane, extended per signed_ld; update_rd_out=1. For a store: update_rd_out=0. Go to IDLE.
  - Counter reaches TIMEOUT_CYCLES (when nonzero) with no ack/error: d_access drops; next cycle fault=1, cause=11. Go to IDLE.
- stall falls in the cycle the bus responds; upstream presents the next instruction the following cycle.
- Latency:
  - Request seen in cycle N; d_access asserted from N+1; ack in cycle M; result valid in M+1.
  - stall=1 for cycles N..M.
  - Minimum memory latency is 2 cycles.
- Bypass (IDLE, no load/store): reg_wr_val<=wr_val, update_rd_out<=update_rd, rd_sel_out<=rd_sel next cycle; stall=0.
- Ignored inputs: d_ack/d_error in IDLE.
- fault_addr holds until the next fault. fault and complete are single-cycle pulses.

Test Plan:
- Word load, addr 0x100, ack after 3 wait cycles, d_data 0xDEADBEEF -> d_bytesel 1111, stall high 4 cycles, then reg_wr_val 0xDEADBEEF, update_rd_out=1, complete=1 for one cycle.
- Signed byte load, addr 0x1003, d_data 0x80123456 -> d_bytesel 1000, reg_wr_val 0xFFFFFF80. Same access with signed_ld=0 -> 0x00000080.
- Half store, addr 0x2002, mdr 0x0000ABCD -> d_addr 0x2000, d_bytesel 1100, d_wr_val 0xABCD0000, d_wr_en=1, update_rd_out=0 after ack.
- Word load, addr 0x3001 -> d_access never asserted; fault=1, fault_cause=01, fault_addr=0x3001 one cycle later.
- d_ack and d_error asserted together -> fault_cause=10, update_rd_out=0. With TIMEOUT_CYCLES=4 and no response -> d_access drops after 4 cycles, fault_cause=11.
- Bypass op (wr_val 0x55, rd_sel 5) back-to-back after a load, and rst asserted mid-BUS -> bypass values appear next cycle with stall=0; after rst, all outputs are 0 and FSM is IDLE.
